// File: rtl/rr_sel_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sel_arbiter_if
//  Purpose  : Handshake bundle for rr_sel_arbiter (two request streams + out).
//  Revision : 1.0  initial release
// ============================================================================
interface rr_sel_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              a_valid;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              sel;

   // slave is the arbiter's view; master is the sources/sink side
   modport slave (
      input  a_valid, a_data, b_valid, b_data, out_ready,
      output a_ready, b_ready, out_valid, out_data, sel
   );
   modport master (
      output a_valid, a_data, b_valid, b_data, out_ready,
      input  a_ready, b_ready, out_valid, out_data, sel
   );
endinterface
`default_nettype wire

// File: rtl/rr_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sel_arbiter
//  Purpose  : Two-input round-robin / fixed-priority arbiter with a registered
//             output word and mux select for the downstream 2:1 mux.
//  Revision : 1.0  initial release
// ============================================================================
module rr_sel_arbiter #(
   parameter int DATA_W = 8,
   parameter bit FAIR   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   rr_sel_arbiter_if.slave   bus
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              sel_q,       sel_d;
   logic              last_grant_q, last_grant_d;
   logic              load;
   logic              grant_a;
   logic              grant_b;

   always_comb begin
      // Gating with rst_n keeps both readies low while reset is asserted.
      load    = rst_n && (!out_valid_q || bus.out_ready);
      grant_a = load && bus.a_valid &&
                (!bus.b_valid || !FAIR || last_grant_q);
      grant_b = load && bus.b_valid &&
                (!bus.a_valid || (FAIR && !last_grant_q));

      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;

      if (grant_a) begin
         out_valid_d  = 1'b1;
         out_data_d   = bus.a_data;
         sel_d        = 1'b0;
         last_grant_d = 1'b0;
      end else if (grant_b) begin
         out_valid_d  = 1'b1;
         out_data_d   = bus.b_data;
         sel_d        = 1'b1;
         last_grant_d = 1'b1;
      end else if (load) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         sel_q        <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.a_ready   = grant_a;
   assign bus.b_ready   = grant_b;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.sel       = sel_q;

endmodule
`default_nettype wire

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Two-input round-robin arbiter that sits directly upstream of the team's 2:1 mux.
- Takes two valid/ready request streams and decides which one is forwarded each cycle.
- Registers the winning word and drives the mux select line (`sel`: 0 = input a, 1 = input b).
- Guarantees no starvation when both sources are continuously valid, and holds output stable under backpressure.

Parameters:
- `DATA_W`, 8, width of each request data word and of `out_data`.
- `FAIR`, 1, 1 = round-robin between a and b; 0 = fixed priority, a always wins ties.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  source a has a word.
- `a_data`  in  DATA_W  source a word.
- `a_ready`  out  1  source a word accepted this cycle.
- `b_valid`  in  1  source b has a word.
- `b_data`  in  DATA_W  source b word.
- `b_ready`  out  1  source b word accepted this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  DATA_W  registered winning word.
- `out_ready`  in  1  downstream consumes word.
- `sel`  out  1  source of the word in the output register (0 = a, 1 = b); drives the mux select.

Behaviour:
- **Clock and reset:** one clock. Reset is asynchronous and active-low: `clk`, `rst_n`.
- **Reset state:**
  - `out_valid`=0, `out_data`=0, `sel`=0.
  - Internal `last_grant`=1, so a wins the first tie.
  - `a_ready`/`b_ready` are combinational and, during reset, evaluate to 0.
- **Load enable:** `load = !out_valid || out_ready`. This allows full throughput of 1 word/cycle.
- **Grant decision** (combinational, only when `load`=1):
  - Only a valid -> grant a. Only b valid -> grant b. Neither -> no grant.
  - Both valid, FAIR=1 -> grant the input not equal to `last_grant`.
  - Both valid, FAIR=0 -> grant a.
- **Ready outputs:**
  - `a_ready = load && grant_a`; `b_ready = load && grant_b`.
  - At most one ready is high in any cycle.
  - Ready never depends on the requester's own ready (no loops).
- **On the clock edge with `load`=1:**
  - If granted: `out_data` <= winner data, `sel` <= winner id, `out_valid` <= 1, `last_grant` <= winner id.
  - If not granted: `out_valid` <= 0. `out_data`, `sel` and `last_grant` keep their values.
- **Backpressure** (`out_valid`=1, `out_ready`=0):
  - `out_data`, `sel` and `out_valid` are held unchanged.
  - Both readies are 0 and `last_grant` is frozen.
- **Latency:** a word accepted at edge N appears on `out_data` with `out_valid`=1 immediately after edge N (1-cycle latency).
- **Simultaneous events:** `out_ready`=1 together with a new grant in the same cycle -> the old word is consumed and the new word is loaded on the same edge; there is no bubble.
- **Input changes:** a requester dropping valid while not granted is legal; no state is affected.
- **Reset mid-transfer:** the pending output word is discarded immediately (asynchronous), and arbitration restarts with a favoured.
- **Ordering:** words from a single source are never reordered or duplicated.

Test Plan:
- **Reset:** hold `rst_n`=0 with both valid=1, `a_data`=8'h11, `b_data`=8'h22 -> `out_valid`=0, `sel`=0, `a_ready`=`b_ready`=0. Release -> first edge loads 8'h11 with `sel`=0.
- **Round-robin:** both valid constantly, `out_ready`=1, FAIR=1, a sends 8'hA0..A3, b sends 8'hB0..B3 -> output sequence A0,B0,A1,B1,A2,B2,A3,B3 with `sel` 0,1,0,1,... and one word per cycle.
- **Fixed priority:** FAIR=0, same stimulus -> A0..A3 consecutively (`sel`=0) and `b_ready`=0 throughout; B0 appears only after `a_valid` drops.
- **Backpressure:** load 8'h5A from b, then hold `out_ready`=0 for 3 cycles while a is valid -> `out_data`=8'h5A, `sel`=1 and `out_valid`=1 stay stable, `a_ready`=0. Raise `out_ready` -> a's word loads on the next edge with `sel`=0.
- **Single source / idle:** only b valid sending 8'h01,8'h02, then none -> output 01,02 with `sel`=1, then `out_valid`=0 while `sel` stays 1.
- **Mid-operation reset:** assert `rst_n`=0 asynchronously between edges while `out_valid`=1 -> `out_valid`=0 and `sel`=0 immediately, without waiting for `clk`. After release with both valid, a wins first.
